// File: rtl/cpu_ctrl_fsm_p.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cpu_ctrl_fsm_p                                                |
// | Purpose  : Datapath controller FSM for MOV/ADD/CMP/AND/MVN plus LDR/STR  |
// |            with a req/ack memory handshake, an ack timeout and a sticky  |
// |            error state for illegal encodings.                            |
// | Ports    : clk, reset (sync, active-high)                                |
// |            s, opcode[2:0], op[1:0], mem_ack        - inputs              |
// |            w, nsel[NSEL_W-1:0], loada/b/c, loads,  - registered outputs  |
// |            asel, bsel, write, vsel[1:0], load_addr,                      |
// |            mem_req, mem_we, err                                          |
// |            halted                                  - CTRL_HALT_EN only   |
// | Options  : `define CTRL_HALT_EN adds the HALT state and halted port.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module cpu_ctrl_fsm_p #(
   parameter int NSEL_W    = 3,
   parameter int TIMEOUT_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s,
   input  logic [2:0]        opcode,
   input  logic [1:0]        op,
   input  logic              mem_ack,
   output logic              w,
   output logic [NSEL_W-1:0] nsel,
   output logic              loada,
   output logic              loadb,
   output logic              loadc,
   output logic              loads,
   output logic              asel,
   output logic              bsel,
   output logic              write,
   output logic [1:0]        vsel,
   output logic              load_addr,
   output logic              mem_req,
   output logic              mem_we,
`ifdef CTRL_HALT_EN
   output logic              halted,
`endif
   output logic              err
);

   typedef enum logic [3:0] {
      S_WAIT   = 4'd0,
      S_GET_A  = 4'd1,
      S_GET_B  = 4'd2,
      S_ALU    = 4'd3,
      S_WB_C   = 4'd4,
      S_WB_IMM = 4'd5,
      S_ADDR   = 4'd6,
      S_MADDR  = 4'd7,
      S_PASS   = 4'd8,
      S_MRD    = 4'd9,
      S_MWR    = 4'd10,
      S_WB_M   = 4'd11,
      S_ERR    = 4'd12,
      S_HALT   = 4'd13
   } state_t;

   typedef struct packed {
      logic       w;
      logic [2:0] nsel;
      logic       loada;
      logic       loadb;
      logic       loadc;
      logic       loads;
      logic       asel;
      logic       bsel;
      logic       write;
      logic [1:0] vsel;
      logic       load_addr;
      logic       mem_req;
      logic       mem_we;
`ifdef CTRL_HALT_EN
      logic       halted;
`endif
      logic       err;
   } ctrl_t;

   // Last count value before the timeout fires: 2^TIMEOUT_W-1 request
   // cycles without ack in total.
   localparam logic [TIMEOUT_W-1:0] c_TO_LAST = {TIMEOUT_W{1'b1}} - 1'b1;

   state_t               state_q, state_d;
   logic [4:0]           ir_q, ir_d;
   logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
   ctrl_t                ctrl_q;

   // Moore output decode; evaluated on the next state so outputs are registered
   // and line up with the state they belong to.
   function automatic ctrl_t decode(input state_t st, input logic [4:0] ir);
      ctrl_t c;
      logic  is_str, is_cmp, is_asel;
      is_str  = (ir[4:2] == 3'b100);
      is_cmp  = (ir == 5'b10101);
      is_asel = (ir == 5'b10111) || (ir == 5'b11000);  // MVN, MOV reg
      c = '0;
      case (st)
         S_WAIT:   c.w = 1'b1;
         S_GET_A:  begin c.nsel = 3'b100; c.loada = 1'b1; end
         S_GET_B:  begin c.nsel = is_str ? 3'b010 : 3'b001; c.loadb = 1'b1; end
         S_ALU:    begin c.loadc = 1'b1; c.asel = is_asel; c.loads = is_cmp; end
         S_WB_C:   begin c.nsel = 3'b010; c.vsel = 2'b11; c.write = 1'b1; end
         S_WB_IMM: begin c.nsel = 3'b100; c.vsel = 2'b01; c.write = 1'b1; end
         S_ADDR:   begin c.bsel = 1'b1; c.loadc = 1'b1; end
         S_MADDR:  c.load_addr = 1'b1;
         S_PASS:   begin c.asel = 1'b1; c.loadc = 1'b1; end
         S_MRD:    c.mem_req = 1'b1;
         S_MWR:    begin c.mem_req = 1'b1; c.mem_we = 1'b1; end
         S_WB_M:   begin c.nsel = 3'b010; c.vsel = 2'b00; c.write = 1'b1; end
         S_ERR:    c.err = 1'b1;
`ifdef CTRL_HALT_EN
         S_HALT:   c.halted = 1'b1;
`endif
         default:  c = '0;
      endcase
      return c;
   endfunction

   always_comb begin
      logic is_mem, is_cmp, is_str;
      state_d = state_q;
      ir_d    = ir_q;
      cnt_d   = '0;
      is_mem  = (ir_q[4:2] == 3'b011) || (ir_q[4:2] == 3'b100);
      is_str  = (ir_q[4:2] == 3'b100);
      is_cmp  = (ir_q == 5'b10101);
      case (state_q)
         S_WAIT: begin
            if (s) begin
               ir_d = {opcode, op};
               case ({opcode, op})
                  5'b10100, 5'b10101, 5'b10110: state_d = S_GET_A;
                  5'b10111, 5'b11000:           state_d = S_GET_B;
                  5'b11010:                     state_d = S_WB_IMM;
                  5'b01100, 5'b10000:           state_d = S_GET_A;
`ifdef CTRL_HALT_EN
                  5'b11100, 5'b11101,
                  5'b11110, 5'b11111:           state_d = S_HALT;
`endif
                  default:                      state_d = S_ERR;
               endcase
            end
         end
         S_GET_A:  state_d = is_mem ? S_ADDR : S_GET_B;
         S_GET_B:  state_d = is_str ? S_PASS : S_ALU;
         S_ALU:    state_d = is_cmp ? S_WAIT : S_WB_C;
         S_ADDR:   state_d = S_MADDR;
         S_MADDR:  state_d = is_str ? S_GET_B : S_MRD;
         S_PASS:   state_d = S_MWR;
         S_MRD, S_MWR: begin
            // Ack wins over a timeout landing in the same cycle.
            if (mem_ack) begin
               state_d = (state_q == S_MRD) ? S_WB_M : S_WAIT;
            end else if (cnt_q == c_TO_LAST) begin
               state_d = S_ERR;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WB_C, S_WB_IMM, S_WB_M: state_d = S_WAIT;
         S_ERR:    state_d = S_ERR;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_ERR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_WAIT;
         ir_q    <= '0;
         cnt_q   <= '0;
         ctrl_q  <= decode(S_WAIT, 5'b00000);
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         cnt_q   <= cnt_d;
         ctrl_q  <= decode(state_d, ir_d);
      end
   end

   always_comb begin
      nsel      = '0;
      nsel[2:0] = ctrl_q.nsel;
   end

   assign w         = ctrl_q.w;
   assign loada     = ctrl_q.loada;
   assign loadb     = ctrl_q.loadb;
   assign loadc     = ctrl_q.loadc;
   assign loads     = ctrl_q.loads;
   assign asel      = ctrl_q.asel;
   assign bsel      = ctrl_q.bsel;
   assign write     = ctrl_q.write;
   assign vsel      = ctrl_q.vsel;
   assign load_addr = ctrl_q.load_addr;
   assign mem_req   = ctrl_q.mem_req;
   assign mem_we    = ctrl_q.mem_we;
   assign err       = ctrl_q.err;
`ifdef CTRL_HALT_EN
   assign halted    = ctrl_q.halted;
`endif

endmodule
`default_nettype wire
